// File: rtl/multi_channel_stream_packer.sv
// multi_channel_stream_packer: FIFO-buffers multi-channel sample sets and streams one AXI-Stream beat per channel with framed tLast (STREAM_CHANNEL_TAG_EN tags beats with the channel index)
module multi_channel_stream_packer #(
    parameter int SAMPLE_W       = 16,
    parameter int CHANNELS       = 2,
    parameter int DATA_W         = 32,
    parameter int FIFO_DEPTH     = 8,
    parameter int MAX_FRAME_LOG2 = 12
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [CHANNELS*SAMPLE_W-1:0] value,
    input  logic                         valueStrobe,
    input  logic [3:0]                   frameSize,
    output logic [DATA_W-1:0]            tData,
    output logic                         tValid,
    output logic                         tLast,
    input  logic                         tReady,
    output logic                         overflow,
    output logic [15:0]                  dropCount
);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CHW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
    localparam int CW  = MAX_FRAME_LOG2 > 0 ? MAX_FRAME_LOG2 : 1;
    localparam int TW  = DATA_W - 3;
    localparam logic [3:0] FS_MAX = MAX_FRAME_LOG2 > 15 ? 4'd15 : 4'(MAX_FRAME_LOG2);
    localparam logic [0:0] S_IDLE = 1'b0, S_STREAM = 1'b1;

    logic [CHANNELS*SAMPLE_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW:0]                  r_wp, r_rp;
    logic [0:0]                   r_state;
    logic [CHW-1:0]               r_ch;
    logic [CW-1:0]                r_cnt;
    logic [3:0]                   r_flog;
    logic [DATA_W-1:0]            r_tdata;
    logic                         r_tvalid, r_tlast, r_overflow;
    logic [15:0]                  r_drops;

    logic                         w_empty, w_full, w_push, w_drop, w_hs, w_last_ch, w_pop, w_load;
    logic [AW:0]                  w_rp_nx;
    logic [CW-1:0]                w_cnt_nx, w_mask_r, w_lmask;
    logic [CHW-1:0]               w_lc;
    logic [3:0]                   w_fs, w_lf;
    logic [CHANNELS*SAMPLE_W-1:0] w_set;
    logic [SAMPLE_W-1:0]          w_samp;
    logic [DATA_W-1:0]            w_ltdata;
    logic                         w_ltlast;

    assign w_empty   = r_wp == r_rp;
    assign w_full    = (r_wp[AW-1:0] == r_rp[AW-1:0]) && (r_wp[AW] != r_rp[AW]);
    assign w_push    = valueStrobe && !w_full;
    assign w_drop    = valueStrobe && w_full;
    assign w_hs      = r_tvalid && tReady;
    assign w_last_ch = r_ch == CHW'(CHANNELS - 1);
    assign w_pop     = w_hs && w_last_ch;
    assign w_rp_nx   = r_rp + {{AW{1'b0}}, w_pop};
    assign w_mask_r  = ~({CW{1'b1}} << r_flog);
    assign w_cnt_nx  = w_pop ? (r_cnt == w_mask_r ? '0 : r_cnt + 1'b1) : r_cnt;
    // A new beat is loaded from IDLE, for the next channel of the same set, or for the next queued set after a pop
    assign w_load    = (r_state == S_IDLE && !w_empty) || (w_hs && !w_last_ch) || (w_pop && w_rp_nx != r_wp);
    assign w_lc      = (w_hs && !w_last_ch) ? r_ch + 1'b1 : '0;
    assign w_fs      = frameSize > FS_MAX ? FS_MAX : frameSize;
    // Frame length is taken from frameSize only when the beat being loaded opens a frame
    assign w_lf      = (w_lc == '0 && w_cnt_nx == '0) ? w_fs : r_flog;
    assign w_lmask   = ~({CW{1'b1}} << w_lf);
    assign w_set     = r_mem[w_rp_nx[AW-1:0]];
    assign w_samp    = w_set[32'(w_lc) * SAMPLE_W +: SAMPLE_W];
    assign w_ltlast  = (w_lc == CHW'(CHANNELS - 1)) && (w_cnt_nx == w_lmask);
`ifdef STREAM_CHANNEL_TAG_EN
    assign w_ltdata  = {3'(w_lc), TW'(signed'(w_samp))};
`else
    assign w_ltdata  = DATA_W'(signed'(w_samp));
`endif

    assign tData     = r_tdata;
    assign tValid    = r_tvalid;
    assign tLast     = r_tlast;
    assign overflow  = r_overflow;
    assign dropCount = r_drops;

    // Sample-set storage; contents need no reset because the pointers define validity
    always_ff @(posedge CLK) begin
        if (w_push) r_mem[r_wp[AW-1:0]] <= value;
    end

    // Write side: push accepted sets, count and flag dropped ones
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wp       <= '0;
            r_overflow <= 1'b0;
            r_drops    <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_drop) begin
                r_overflow <= 1'b1;
                r_drops    <= r_drops == 16'hFFFF ? r_drops : r_drops + 1'b1;
            end
        end
    end

    // Read side: output register, channel/frame counters and the IDLE/STREAM state
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_rp     <= '0;
            r_state  <= S_IDLE;
            r_ch     <= '0;
            r_cnt    <= '0;
            r_flog   <= '0;
            r_tdata  <= '0;
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
        end else begin
            r_rp  <= w_rp_nx;
            r_cnt <= w_cnt_nx;
            if (w_hs) r_ch <= w_lc;
            if (w_load) begin
                r_state  <= S_STREAM;
                r_tdata  <= w_ltdata;
                r_tvalid <= 1'b1;
                r_tlast  <= w_ltlast;
                if (w_lc == '0 && w_cnt_nx == '0) r_flog <= w_fs;
            end else if (w_hs) begin
                r_state  <= S_IDLE;
                r_tvalid <= 1'b0;
                r_tlast  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_multi_channel_stream_packer.sv
// tb_multi_channel_stream_packer: directed checks of latency, framing, overflow, backpressure and reset
module tb_multi_channel_stream_packer;
    logic        CLK = 1'b0, RST = 1'b1;
    logic [31:0] value = '0;
    logic        valueStrobe = 1'b0;
    logic [3:0]  frameSize = 4'd2;
    logic [31:0] tData;
    logic        tValid, tLast, overflow;
    logic        tReady = 1'b1;
    logic [15:0] dropCount;
    int          n_checks = 0, n_errors = 0;

    multi_channel_stream_packer dut (
        .CLK(CLK), .RST(RST), .value(value), .valueStrobe(valueStrobe), .frameSize(frameSize),
        .tData(tData), .tValid(tValid), .tLast(tLast), .tReady(tReady),
        .overflow(overflow), .dropCount(dropCount)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ex(input logic [15:0] s, input int c);
`ifdef STREAM_CHANNEL_TAG_EN
        return {c[2:0], {13{s[15]}}, s};
`else
        return {{16{s[15]}}, s};
`endif
    endfunction

    task automatic send_set(input logic [15:0] s0, input logic [15:0] s1, input logic lst);
        value = {s1, s0};
        valueStrobe = 1'b1;
        tick();
        valueStrobe = 1'b0;
        chk("lat_not_yet", tValid, 1'b0);
        tick();
        chk("beat0_valid", tValid, 1'b1);
        chk("beat0_data", tData, ex(s0, 0));
        chk("beat0_last", tLast, 1'b0);
        tick();
        chk("beat1_valid", tValid, 1'b1);
        chk("beat1_data", tData, ex(s1, 1));
        chk("beat1_last", tLast, lst);
        tick();
        chk("after_set_idle", tValid, 1'b0);
        repeat (12) tick();
    endtask

    initial begin
        int got, sent, lasts, s, c;
        logic pv, pr, pl, el;
        logic [31:0] pd;
        tick();
        tick();
        chk("rst_tvalid", tValid, 1'b0);
        chk("rst_tdata", tData, 32'h0);
        chk("rst_tlast", tLast, 1'b0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_dropcount", dropCount, 16'h0);
        RST = 1'b0;
        tick();
        send_set(16'h0001, 16'h0002, 1'b0);
        send_set(16'h0003, 16'h0004, 1'b0);
        send_set(16'h8000, 16'hFFFE, 1'b0);
        send_set(16'h0007, 16'h0008, 1'b1);

        tReady = 1'b0;
        for (int i = 0; i < 10; i++) begin
            value = {16'(16'h0200 + i), 16'(16'h0100 + i)};
            valueStrobe = 1'b1;
            tick();
        end
        valueStrobe = 1'b0;
        tick();
        chk("ovf_flag", overflow, 1'b1);
        chk("ovf_drops", dropCount, 16'd2);
        tReady = 1'b1;
        for (int b = 0; b < 16; b++) begin
            chk("burst_valid", tValid, 1'b1);
            chk("burst_data", tData, ex(b[0] ? 16'(16'h0200 + b / 2) : 16'(16'h0100 + b / 2), b % 2));
            chk("burst_last", tLast, b == 7 || b == 15);
            tick();
        end
        chk("burst_drained", tValid, 1'b0);

        frameSize = 4'd9;
        got = 0; sent = 0; lasts = 0;
        pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0;
        for (int cyc = 0; cyc < 8000 && got < 1056; cyc++) begin
            if (pv && !pr) begin
                chk("hold_data", tData, pd);
                chk("hold_last", tLast, pl);
                chk("hold_valid", tValid, 1'b1);
            end
            tReady = cyc[0];
            if (tValid && tReady) begin
                s = got / 2;
                c = got % 2;
                el = c == 1 && (s == 511 || (s >= 512 && (s - 512) % 8 == 7));
                chk("tog_data", tData, ex(c == 1 ? 16'(16'h8000 | s) : 16'(s * 3), c));
                chk("tog_last", tLast, el);
                if (tLast) lasts++;
                got++;
            end
            pv = tValid; pr = tReady; pd = tData; pl = tLast;
            if (cyc % 5 == 0 && sent < 528) begin
                value = {16'(16'h8000 | sent), 16'(sent * 3)};
                valueStrobe = 1'b1;
                sent++;
                if (sent == 100) frameSize = 4'd3;
            end else valueStrobe = 1'b0;
            tick();
        end
        valueStrobe = 1'b0;
        chk("tog_beats", got, 1056);
        chk("tog_lasts", lasts, 3);
        chk("tog_drops_kept", dropCount, 16'd2);

        tReady = 1'b1;
        frameSize = 4'd2;
        repeat (4) tick();
        send_set(16'h0011, 16'h0012, 1'b0);
        tReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            value = {16'h0AAA, 16'h0555};
            valueStrobe = 1'b1;
            tick();
        end
        valueStrobe = 1'b0;
        tick();
        chk("pre_rst_valid", tValid, 1'b1);
        RST = 1'b1;
        #1;
        chk("arst_tvalid", tValid, 1'b0);
        chk("arst_tdata", tData, 32'h0);
        chk("arst_tlast", tLast, 1'b0);
        chk("arst_overflow", overflow, 1'b0);
        chk("arst_dropcount", dropCount, 16'h0);
        tick();
        RST = 1'b0;
        tReady = 1'b1;
        frameSize = 4'd1;
        tick();
        chk("post_rst_empty", tValid, 1'b0);
        send_set(16'h0021, 16'h0022, 1'b0);
        send_set(16'h0023, 16'h0024, 1'b1);
        chk("post_rst_overflow", overflow, 1'b0);
        chk("post_rst_dropcount", dropCount, 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
